// File: rtl/jtag_axi4l_master_ctrl.sv
// JTAG-to-AXI4-Lite master bridge.
// A virtual JTAG TAP shifts a 32-bit data register through tdi/tdo. The
// current virtual instruction selects which internal register is captured
// and updated. Update-DR events on the WDATA and RD instructions launch
// single AXI4-Lite transactions. Every transaction is bounded by a cycle
// timeout.
module jtag_axi4l_master_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tdi,
    output logic                  tdo,
    input  logic [5:0]            ir_in,
    output logic [5:0]            ir_out,
    input  logic                  virtual_state_cdr,
    input  logic                  virtual_state_sdr,
    input  logic                  virtual_state_udr,
    input  logic                  virtual_state_cir,
    input  logic                  virtual_state_uir,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [5:0] IR_ADDR   = 6'h01;
    localparam logic [5:0] IR_WDATA  = 6'h02;
    localparam logic [5:0] IR_RD     = 6'h03;
    localparam logic [5:0] IR_RDATA  = 6'h04;
    localparam logic [5:0] IR_STATUS = 6'h05;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4
    } state_t;

    state_t                state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [31:0]           sr_r;
    logic [ADDR_WIDTH-1:0] addr_reg_r;
    logic [31:0]           wdata_reg_r;
    logic [31:0]           rdata_reg_r, rdata_reg_s;
    logic [1:0]            resp_r, resp_s;
    logic                  timeout_r, timeout_s;
    logic                  overrun_r, overrun_s;
    logic                  awvalid_r, awvalid_s;
    logic                  wvalid_r, wvalid_s;
    logic                  bready_r, bready_s;
    logic                  arvalid_r, arvalid_s;
    logic                  rready_r, rready_s;
    logic [ADDR_WIDTH-1:0] awaddr_r, awaddr_s;
    logic [ADDR_WIDTH-1:0] araddr_r, araddr_s;
    logic [31:0]           wdata_out_r, wdata_out_s;

    logic                  busy_s;
    logic                  start_wr_s;
    logic                  start_rd_s;
    logic                  status_clr_s;
    logic [31:0]           capture_s;
    logic                  unused_s;

    // The TAP captures IR through cir; the bridge itself needs neither IR strobe.
    assign unused_s = ^{virtual_state_cir, virtual_state_uir};

    assign busy_s       = (state_r != ST_IDLE);
    assign start_wr_s   = virtual_state_udr && (ir_in == IR_WDATA) && !busy_s;
    assign start_rd_s   = virtual_state_udr && (ir_in == IR_RD) && !busy_s;
    assign status_clr_s = virtual_state_udr && (ir_in == IR_STATUS) && sr_r[0];

    assign tdo           = sr_r[0];
    assign ir_out        = {timeout_r, overrun_r, resp_r, busy_s, 1'b0};
    assign m_axi_awaddr  = awaddr_r;
    assign m_axi_awvalid = awvalid_r;
    assign m_axi_wdata   = wdata_out_r;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_r;
    assign m_axi_bready  = bready_r;
    assign m_axi_araddr  = araddr_r;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = rready_r;

    // Select the value loaded into the shift register on Capture-DR.
    always_comb begin
        capture_s = 32'h0000_0000;
        case (ir_in)
            IR_ADDR:   capture_s = 32'(addr_reg_r);
            IR_WDATA:  capture_s = wdata_reg_r;
            IR_RD:     capture_s = 32'h0000_0000;
            IR_RDATA:  capture_s = rdata_reg_r;
            IR_STATUS: capture_s = {27'b0, timeout_r, overrun_r, resp_r, busy_s};
            default:   capture_s = 32'h0000_0000;
        endcase
    end

    // JTAG data register: capture, shift, and the update of the ADDR/WDATA holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_r        <= 32'h0000_0000;
            addr_reg_r  <= '0;
            wdata_reg_r <= 32'h0000_0000;
        end else begin
            if (virtual_state_cdr) begin
                sr_r <= capture_s;
            end else if (virtual_state_sdr) begin
                sr_r <= {tdi, sr_r[31:1]};
            end else begin
                sr_r <= sr_r;
            end
            if (virtual_state_udr && (ir_in == IR_ADDR)) begin
                addr_reg_r <= sr_r[ADDR_WIDTH-1:0];
            end else begin
                addr_reg_r <= addr_reg_r;
            end
            if (virtual_state_udr && (ir_in == IR_WDATA)) begin
                wdata_reg_r <= sr_r;
            end else begin
                wdata_reg_r <= wdata_reg_r;
            end
        end
    end

    // Transaction FSM next state: AXI channel controls, timeout, and sticky status.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        awvalid_s   = awvalid_r;
        wvalid_s    = wvalid_r;
        bready_s    = bready_r;
        arvalid_s   = arvalid_r;
        rready_s    = rready_r;
        awaddr_s    = awaddr_r;
        araddr_s    = araddr_r;
        wdata_out_s = wdata_out_r;
        rdata_reg_s = rdata_reg_r;
        resp_s      = resp_r;
        timeout_s   = timeout_r;
        overrun_s   = overrun_r;

        // A busy udr also covers the cycle in which the FSM is returning to IDLE.
        if (virtual_state_udr && busy_s && ((ir_in == IR_WDATA) || (ir_in == IR_RD))) begin
            overrun_s = 1'b1;
        end else if (status_clr_s) begin
            overrun_s = 1'b0;
            timeout_s = 1'b0;
        end else begin
            overrun_s = overrun_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (start_wr_s) begin
                    state_s     = ST_WR;
                    cnt_s       = '0;
                    awvalid_s   = 1'b1;
                    wvalid_s    = 1'b1;
                    awaddr_s    = addr_reg_r;
                    // wdata_reg_r is written from sr_r on this same edge.
                    wdata_out_s = sr_r;
                end else if (start_rd_s) begin
                    state_s   = ST_RD_ADDR;
                    cnt_s     = '0;
                    arvalid_s = 1'b1;
                    araddr_s  = addr_reg_r;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                if (cnt_r == TO_LAST) begin
                    state_s   = ST_IDLE;
                    awvalid_s = 1'b0;
                    wvalid_s  = 1'b0;
                    bready_s  = 1'b0;
                    arvalid_s = 1'b0;
                    rready_s  = 1'b0;
                    timeout_s = 1'b1;
                    resp_s    = 2'b11;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                    case (state_r)
                        ST_WR: begin
                            if (awvalid_r && m_axi_awready) begin
                                awvalid_s = 1'b0;
                            end else begin
                                awvalid_s = awvalid_r;
                            end
                            if (wvalid_r && m_axi_wready) begin
                                wvalid_s = 1'b0;
                            end else begin
                                wvalid_s = wvalid_r;
                            end
                            if ((!awvalid_r || m_axi_awready) && (!wvalid_r || m_axi_wready)) begin
                                state_s  = ST_WR_RESP;
                                bready_s = 1'b1;
                            end else begin
                                state_s = ST_WR;
                            end
                        end
                        ST_WR_RESP: begin
                            if (m_axi_bvalid) begin
                                resp_s   = m_axi_bresp;
                                bready_s = 1'b0;
                                state_s  = ST_IDLE;
                            end else begin
                                state_s = ST_WR_RESP;
                            end
                        end
                        ST_RD_ADDR: begin
                            if (m_axi_arready) begin
                                arvalid_s = 1'b0;
                                rready_s  = 1'b1;
                                state_s   = ST_RD_DATA;
                            end else begin
                                state_s = ST_RD_ADDR;
                            end
                        end
                        ST_RD_DATA: begin
                            if (m_axi_rvalid) begin
                                rdata_reg_s = m_axi_rdata;
                                resp_s      = m_axi_rresp;
                                rready_s    = 1'b0;
                                state_s     = ST_IDLE;
                            end else begin
                                state_s = ST_RD_DATA;
                            end
                        end
                        default: begin
                            state_s   = ST_IDLE;
                            awvalid_s = 1'b0;
                            wvalid_s  = 1'b0;
                            bready_s  = 1'b0;
                            arvalid_s = 1'b0;
                            rready_s  = 1'b0;
                        end
                    endcase
                end
            end
        endcase
    end

    // Transaction FSM state and registered AXI outputs; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            bready_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            awaddr_r    <= '0;
            araddr_r    <= '0;
            wdata_out_r <= 32'h0000_0000;
            rdata_reg_r <= 32'h0000_0000;
            resp_r      <= 2'b00;
            timeout_r   <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            awvalid_r   <= awvalid_s;
            wvalid_r    <= wvalid_s;
            bready_r    <= bready_s;
            arvalid_r   <= arvalid_s;
            rready_r    <= rready_s;
            awaddr_r    <= awaddr_s;
            araddr_r    <= araddr_s;
            wdata_out_r <= wdata_out_s;
            rdata_reg_r <= rdata_reg_s;
            resp_r      <= resp_s;
            timeout_r   <= timeout_s;
            overrun_r   <= overrun_s;
        end
    end

endmodule

// File: tb/tb_jtag_axi4l_master_ctrl.sv
// Directed testbench for the JTAG-to-AXI4-Lite master bridge.
module tb_jtag_axi4l_master_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tdi = 1'b0;
    logic        tdo;
    logic [5:0]  ir_in = 6'h00;
    logic [5:0]  ir_out;
    logic        cdr = 1'b0, sdr = 1'b0, udr = 1'b0, cir = 1'b0, uir = 1'b0;
    logic [31:0] awaddr, araddr, wdata;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = 32'h0;

    int vectors = 0;
    int miscompares = 0;

    jtag_axi4l_master_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .rst_n(rst_n), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
        .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_udr(udr),
        .virtual_state_cir(cir), .virtual_state_uir(uir),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    always #5 clk = ~clk;

    // One full DR scan: capture, 32 shifts (LSB first), update.
    task automatic dr_scan(input logic [5:0] ir, input logic [31:0] din, output logic [31:0] dout);
        @(negedge clk);
        ir_in = ir;
        cdr = 1'b1;
        @(negedge clk);
        cdr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            sdr = 1'b1;
            tdi = din[i];
            dout[i] = tdo;
            @(negedge clk);
        end
        sdr = 1'b0;
        udr = 1'b1;
        @(negedge clk);
        udr = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if (awvalid !== 1'b0) begin miscompares++; $display("FAIL reset_awvalid got %b want 0", awvalid); end
        vectors++; if ({wvalid, bready, arvalid, rready} !== 4'b0000) begin miscompares++; $display("FAIL reset_ctrl got %b want 0000", {wvalid, bready, arvalid, rready}); end
        vectors++; if (tdo !== 1'b0) begin miscompares++; $display("FAIL reset_tdo got %b want 0", tdo); end
        vectors++; if (wstrb !== 4'hF) begin miscompares++; $display("FAIL reset_wstrb got %h want f", wstrb); end
        vectors++; if (ir_out !== 6'h00) begin miscompares++; $display("FAIL reset_ir_out got %h want 00", ir_out); end
        vectors++; if ({awaddr, wdata, araddr} !== 96'h0) begin miscompares++; $display("FAIL reset_addr_data got %h want 0", {awaddr, wdata, araddr}); end
    endtask

    task automatic test_write_basic();
        logic [31:0] d;
        dr_scan(6'h01, 32'h0000_1000, d);
        dr_scan(6'h02, 32'hDEAD_BEEF, d);
        vectors++; if (awvalid !== 1'b1 || wvalid !== 1'b1) begin miscompares++; $display("FAIL wr_valids got %b%b want 11", awvalid, wvalid); end
        vectors++; if (awaddr !== 32'h0000_1000) begin miscompares++; $display("FAIL wr_awaddr got %h want 00001000", awaddr); end
        vectors++; if (wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr_wdata got %h want deadbeef", wdata); end
        vectors++; if (ir_out[1] !== 1'b1) begin miscompares++; $display("FAIL wr_busy got %b want 1", ir_out[1]); end
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0;
        vectors++; if ({awvalid, wvalid, bready} !== 3'b001) begin miscompares++; $display("FAIL wr_to_resp got %b want 001", {awvalid, wvalid, bready}); end
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        bvalid = 1'b0;
        vectors++; if (bready !== 1'b0 || ir_out[1] !== 1'b0) begin miscompares++; $display("FAIL wr_done got bready=%b busy=%b want 0 0", bready, ir_out[1]); end
        dr_scan(6'h05, 32'h0, d);
        vectors++; if (d !== 32'h0000_0000) begin miscompares++; $display("FAIL wr_status got %h want 00000000", d); end
    endtask

    task automatic test_write_aw_first();
        logic [31:0] d;
        dr_scan(6'h02, 32'h0000_00A5, d);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        vectors++; if ({awvalid, wvalid} !== 2'b01) begin miscompares++; $display("FAIL awfirst_split got %b want 01", {awvalid, wvalid}); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++; if ({awvalid, wvalid, bready} !== 3'b010) begin miscompares++; $display("FAIL awfirst_wait%0d got %b want 010", i, {awvalid, wvalid, bready}); end
        end
        vectors++; if (wdata !== 32'h0000_00A5) begin miscompares++; $display("FAIL awfirst_wdata got %h want 000000a5", wdata); end
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        vectors++; if ({wvalid, bready} !== 2'b01) begin miscompares++; $display("FAIL awfirst_bready got %b want 01", {wvalid, bready}); end
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        vectors++; if (ir_out[1] !== 1'b0) begin miscompares++; $display("FAIL awfirst_idle got %b want 0", ir_out[1]); end
    endtask

    task automatic test_read();
        logic [31:0] d;
        dr_scan(6'h01, 32'h0000_0020, d);
        dr_scan(6'h03, 32'h0, d);
        vectors++; if (arvalid !== 1'b1 || araddr !== 32'h0000_0020) begin miscompares++; $display("FAIL rd_ar got v=%b a=%h want 1 00000020", arvalid, araddr); end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        vectors++; if ({arvalid, rready} !== 2'b01) begin miscompares++; $display("FAIL rd_to_data got %b want 01", {arvalid, rready}); end
        rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b10;
        @(negedge clk);
        rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        vectors++; if (rready !== 1'b0) begin miscompares++; $display("FAIL rd_rready_drop got %b want 0", rready); end
        dr_scan(6'h04, 32'h0, d);
        vectors++; if (d !== 32'h1234_5678) begin miscompares++; $display("FAIL rd_rdata got %h want 12345678", d); end
        dr_scan(6'h05, 32'h0, d);
        vectors++; if (d !== 32'h0000_0004) begin miscompares++; $display("FAIL rd_status got %h want 00000004", d); end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        dr_scan(6'h01, 32'h0000_0040, d);
        dr_scan(6'h03, 32'h0, d);
        dr_scan(6'h03, 32'h0, d);
        vectors++; if (ir_out[4] !== 1'b1) begin miscompares++; $display("FAIL ovr_set got %b want 1", ir_out[4]); end
        vectors++; if (arvalid !== 1'b1 || araddr !== 32'h0000_0040) begin miscompares++; $display("FAIL ovr_ar_held got v=%b a=%h want 1 00000040", arvalid, araddr); end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1; rresp = 2'b00;
        @(negedge clk);
        rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (arvalid !== 1'b0 || ir_out[1] !== 1'b0) begin miscompares++; $display("FAIL ovr_no_second%0d got v=%b busy=%b want 0 0", i, arvalid, ir_out[1]); end
        end
        dr_scan(6'h05, 32'h0000_0001, d);
        vectors++; if (d !== 32'h0000_0008) begin miscompares++; $display("FAIL ovr_status got %h want 00000008", d); end
        vectors++; if (ir_out !== 6'h00) begin miscompares++; $display("FAIL ovr_cleared got %h want 00", ir_out); end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        int n;
        dr_scan(6'h03, 32'h0, d);
        n = 0;
        while (arvalid === 1'b1 && n < 1100) begin
            n++;
            @(negedge clk);
        end
        vectors++; if (n !== 1024) begin miscompares++; $display("FAIL to_cycles got %0d want 1024", n); end
        vectors++; if (arvalid !== 1'b0 || ir_out[1] !== 1'b0) begin miscompares++; $display("FAIL to_idle got v=%b busy=%b want 0 0", arvalid, ir_out[1]); end
        dr_scan(6'h05, 32'h0, d);
        vectors++; if (d !== 32'h0000_0016) begin miscompares++; $display("FAIL to_status got %h want 00000016", d); end
        dr_scan(6'h05, 32'h0000_0001, d);
        vectors++; if (ir_out !== 6'h0C) begin miscompares++; $display("FAIL to_cleared got %h want 0c", ir_out); end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d;
        dr_scan(6'h01, 32'h0000_0300, d);
        dr_scan(6'h02, 32'hCAFE_0001, d);
        vectors++; if (awvalid !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre got %b want 1", awvalid); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if ({awvalid, wvalid, bready, arvalid, rready, tdo} !== 6'b000000) begin miscompares++; $display("FAIL rstmid_ctrl got %b want 000000", {awvalid, wvalid, bready, arvalid, rready, tdo}); end
        vectors++; if ({awaddr, wdata} !== 64'h0 || ir_out !== 6'h00) begin miscompares++; $display("FAIL rstmid_data got %h ir=%h want 0 00", {awaddr, wdata}, ir_out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (ir_out !== 6'h00 || awvalid !== 1'b0) begin miscompares++; $display("FAIL rstmid_after got ir=%h v=%b want 00 0", ir_out, awvalid); end
        dr_scan(6'h02, 32'h0, d);
        vectors++; if (d !== 32'h0000_0000) begin miscompares++; $display("FAIL rstmid_wdata_reg got %h want 00000000", d); end
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
    endtask

    initial begin
        #3;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_write_basic();
        test_write_aw_first();
        test_read();
        test_overrun();
        test_timeout();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jtag_axi4l_master_ctrl.md
JTAG_AXI4L_MASTER_CTRL -- requirements
Module: jtag_axi4l_master_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, maximum cycles per AXI transaction before abort.
REQ-003 Port clk, input, 1, single clock; all inputs are synchronous to clk.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Ports tdi (input, 1) and tdo (output, 1) carry the virtual JTAG serial data in and out.
REQ-006 Ports ir_in (input, 6) and ir_out (output, 6) carry the current virtual instruction and the IR capture value.
REQ-007 Ports virtual_state_cdr/sdr/udr/cir/uir are inputs, 1 bit each, and are the virtual TAP state strobes.
REQ-008 Write channel ports: m_axi_awaddr out ADDR_WIDTH, m_axi_awvalid out 1, m_axi_awready in 1, m_axi_wdata out 32, m_axi_wstrb out 4, m_axi_wvalid out 1, m_axi_wready in 1.
REQ-009 Write response ports: m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1.
REQ-010 Read ports: m_axi_araddr out ADDR_WIDTH, m_axi_arvalid out 1, m_axi_arready in 1, m_axi_rdata in 32, m_axi_rresp in 2, m_axi_rvalid in 1, m_axi_rready out 1.

Function
REQ-011 IR decode: 0x01 ADDR, 0x02 WDATA, 0x03 RD, 0x04 RDATA, 0x05 STATUS; any other code is BYPASS.
REQ-012 DR is a 32-bit shift register sr for every instruction.
REQ-013 On virtual_state_cdr, sr loads: ADDR->addr_reg (zero-extended), WDATA->wdata_reg, RD->0, RDATA->rdata_reg, STATUS->{27'b0,timeout,overrun,resp[1:0],busy}, BYPASS->0.
REQ-014 On virtual_state_sdr, sr <= {tdi, sr[31:1]}; tdo is combinationally sr[0].
REQ-015 cdr has priority over sdr if both are asserted; sr holds in all other cycles.
REQ-016 On udr with ADDR, addr_reg <= sr[ADDR_WIDTH-1:0], independent of busy.
REQ-017 On udr with WDATA: wdata_reg <= sr; if FSM is IDLE, start a write; otherwise set overrun and start no transaction.
REQ-018 On udr with RD: if FSM is IDLE, start a read; otherwise set overrun.
REQ-019 On udr with STATUS and sr[0]=1, clear timeout and overrun.
REQ-020 On udr with RDATA or BYPASS, no action.
REQ-021 The FSM has states IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA; busy = (state != IDLE).
REQ-022 Write start: in the next cycle, m_axi_awvalid=1 and m_axi_wvalid=1 with awaddr=addr_reg, wdata=wdata_reg, wstrb=4'hF.
REQ-023 Each of awvalid and wvalid drops in the cycle after its own ready is sampled high; their order is independent, and same-cycle completion is legal.
REQ-024 When both AW and W handshakes are complete, go to WR_RESP with bready=1; on bvalid, resp <= bresp, bready drops, and the FSM returns to IDLE.
REQ-025 Read start: the next cycle asserts arvalid with araddr=addr_reg; on arready, go to RD_DATA with rready=1; on rvalid, rdata_reg <= rdata, resp <= rresp, and the FSM returns to IDLE.
REQ-026 AXI address and data outputs are held stable while their valid is high.
REQ-027 A timeout counter resets to 0 on each transaction start and increments every non-IDLE cycle.
REQ-028 On reaching TIMEOUT_CYCLES-1, all valid and ready outputs drop, timeout is set, resp <= 2'b11, and the FSM returns to IDLE.
REQ-029 ir_out = {timeout, overrun, resp[1:0], busy, 1'b0} continuously, captured by the TAP on cir.
REQ-030 virtual_state_uir is ignored.
REQ-031 A udr arriving in the same cycle that the FSM returns to IDLE is treated as busy (overrun).

Reset
REQ-032 While rst_n=0, the following are 0: sr, addr_reg, wdata_reg, rdata_reg, resp, timeout, overrun, the timeout counter, and every AXI valid/ready output.
REQ-033 While rst_n=0, the FSM is IDLE, tdo=0, and m_axi_wstrb=4'hF.
REQ-034 Reset asserted mid-transaction aborts it immediately, with no completion or status update.

Verification
REQ-035 Shift 0x0000_1000 under ADDR, then 0xDEAD_BEEF under WDATA -> awaddr=0x1000, wdata=0xDEADBEEF; with awready=wready=1 and bresp=0, the FSM returns to IDLE and STATUS reads 0x00000000.
REQ-036 AW ready 3 cycles before W ready -> awvalid drops first, wvalid stays high until wready, then bready=1.
REQ-037 ADDR=0x20, RD, then rdata=0x12345678 with rresp=2'b10 -> an RDATA shift-out yields 0x12345678 and STATUS yields 0x00000004.
REQ-038 Slave never asserts arready -> after 1024 cycles arvalid=0, and STATUS=0x00000016.
REQ-039 A second RD udr while busy -> overrun=1 with no second arvalid; a STATUS write of 0x1 clears it.
REQ-040 rst_n pulsed low while awvalid=1 -> all outputs read 0 in the same cycle, and the FSM is IDLE after release.
